// File: rtl/seg_display_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner: per-digit dp and blink, 16-level PWM,
// dead-time blanking per slot, and data shadowed so it only changes at frame boundaries.
module seg_display_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 32768,
    parameter int BLANK_CYCLES = 256,
    parameter int BLINK_FRAMES = 128
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    load,
    input  logic [3:0]              brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);
    localparam int SLOT_W = $clog2(SLOT_CYCLES);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] BLANK_END = SLOT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
    localparam logic [5*NUM_DIGITS-1:0] ALL_BLANK = {NUM_DIGITS{5'd31}};

    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] s;
        case (code)
            5'd0:    s = 7'h40;
            5'd1:    s = 7'h79;
            5'd2:    s = 7'h24;
            5'd3:    s = 7'h30;
            5'd4:    s = 7'h19;
            5'd5:    s = 7'h12;
            5'd6:    s = 7'h02;
            5'd7:    s = 7'h78;
            5'd8:    s = 7'h00;
            5'd9:    s = 7'h10;
            5'd10:   s = 7'h3F;
            5'd11:   s = 7'h06;
            5'd12:   s = 7'h2F;
            5'd13:   s = 7'h47;
            5'd14:   s = 7'h09;
            5'd15:   s = 7'h41;
            5'd16:   s = 7'h0C;
            5'd17:   s = 7'h23;
            5'd18:   s = 7'h03;
            5'd19:   s = 7'h21;
            5'd20:   s = 7'h2B;
            5'd21:   s = 7'h71;
            5'd22:   s = 7'h11;
            5'd30:   s = 7'h0B;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [SLOT_W-1:0]       slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
    logic [FRM_W-1:0]        frame_cnt_q, frame_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [5*NUM_DIGITS-1:0] data_act_q, data_act_d, data_pend_q, data_pend_d;
    logic [NUM_DIGITS-1:0]   dp_act_q, dp_act_d, dp_pend_q, dp_pend_d;
    logic [NUM_DIGITS-1:0]   blink_act_q, blink_act_d, blink_pend_q, blink_pend_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_tick_q, frame_tick_d;

    logic                    slot_end, frame_end, lit;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic [4:0]              cur_code;
    logic                    cur_dp, cur_blink;
    logic [6:0]              cur_seg;

    assign slot_end  = (slot_cnt_q == SLOT_LAST);
    assign frame_end = slot_end && (digit_idx_q == '0);

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_sel
        assign digit_sel[gi] = (digit_idx_q == IDX_W'(gi));
    end

    // One-hot OR-mux keeps the selection in range even when NUM_DIGITS is not a power of 2.
    always_comb begin
        cur_code  = 5'd31;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_sel[k]) begin
                cur_code  = data_act_q[5*k +: 5];
                cur_dp    = dp_act_q[k];
                cur_blink = blink_act_q[k];
            end
        end
    end

    assign cur_seg = seg_decode(cur_code);

    always_comb begin
        slot_cnt_d    = slot_end ? '0 : slot_cnt_q + SLOT_W'(1);
        digit_idx_d   = digit_idx_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        data_act_d    = data_act_q;
        dp_act_d      = dp_act_q;
        blink_act_d   = blink_act_q;
        data_pend_d   = data_pend_q;
        dp_pend_d     = dp_pend_q;
        blink_pend_d  = blink_pend_q;
        pend_valid_d  = pend_valid_q;

        if (slot_end) begin
            digit_idx_d = (digit_idx_q == '0) ? IDX_LAST : digit_idx_q - IDX_W'(1);
        end

        if (frame_end) begin
            if (frame_cnt_q == FRM_LAST) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FRM_W'(1);
            end
        end

        // A load landing on the boundary cycle bypasses the shadow.
        if (frame_end) begin
            if (load) begin
                data_act_d  = data_in;
                dp_act_d    = dp_in;
                blink_act_d = blink_mask;
            end else if (pend_valid_q) begin
                data_act_d  = data_pend_q;
                dp_act_d    = dp_pend_q;
                blink_act_d = blink_pend_q;
            end
            pend_valid_d = 1'b0;
        end else if (load) begin
            data_pend_d  = data_in;
            dp_pend_d    = dp_in;
            blink_pend_d = blink_mask;
            pend_valid_d = 1'b1;
        end

        // A digit with nothing lit keeps its anode off as well.
        lit = (slot_cnt_q >= BLANK_END)
           && (slot_cnt_q[SLOT_W-1 -: 4] <= brightness)
           && !(blink_phase_q && cur_blink)
           && ((cur_seg != 7'h7F) || cur_dp);

        an_d         = lit ? ~digit_sel : '1;
        seg_d        = lit ? cur_seg : 7'h7F;
        dp_d         = lit ? ~cur_dp : 1'b1;
        frame_tick_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt_q    <= '0;
            digit_idx_q   <= IDX_LAST;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            data_act_q    <= ALL_BLANK;
            dp_act_q      <= '0;
            blink_act_q   <= '0;
            data_pend_q   <= ALL_BLANK;
            dp_pend_q     <= '0;
            blink_pend_q  <= '0;
            pend_valid_q  <= 1'b0;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            an_q          <= '1;
            frame_tick_q  <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            digit_idx_q   <= digit_idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            data_act_q    <= data_act_d;
            dp_act_q      <= dp_act_d;
            blink_act_q   <= blink_act_d;
            data_pend_q   <= data_pend_d;
            dp_pend_q     <= dp_pend_d;
            blink_pend_q  <= blink_pend_d;
            pend_valid_q  <= pend_valid_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            frame_tick_q  <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_display_scan_ctrl.sv
// Self-checking bench for seg_display_scan_ctrl: per-cycle scoreboard on a 4-digit instance,
// table-driven decoder vectors, and hand sequences for brightness, blink, shadowing, reset and an 8-digit scan.
module tb_seg_display_scan_ctrl;
    localparam int N  = 4;
    localparam int S  = 64;
    localparam int B  = 2;
    localparam int BF = 2;
    localparam int FR = N * S;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blink_mask = '0;
    logic        load = 1'b0;
    logic [3:0]  brightness = 4'd15;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    logic [39:0] data8 = '0;
    logic [7:0]  dp8 = '0;
    logic [7:0]  blink8 = '0;
    logic        load8 = 1'b0;
    logic [6:0]  seg8;
    logic        dp8_out;
    logic [7:0]  an8;
    logic        tick8;

    always #5 clk = ~clk;

    seg_display_scan_ctrl #(.NUM_DIGITS(4), .SLOT_CYCLES(S), .BLANK_CYCLES(B), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in), .blink_mask(blink_mask),
        .load(load), .brightness(brightness), .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick));

    seg_display_scan_ctrl #(.NUM_DIGITS(8), .SLOT_CYCLES(S), .BLANK_CYCLES(B), .BLINK_FRAMES(BF)) dut8 (
        .clk(clk), .reset(reset), .data_in(data8), .dp_in(dp8), .blink_mask(blink8),
        .load(load8), .brightness(brightness), .seg(seg8), .dp(dp8_out), .an(an8), .frame_tick(tick8));

    int checks = 0;
    int fails  = 0;

    function automatic logic [6:0] ref_seg(input int c);
        case (c)
            0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
            4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
            8: return 7'h00;   9: return 7'h10;  10: return 7'h3F;  11: return 7'h06;
           12: return 7'h2F;  13: return 7'h47;  14: return 7'h09;  15: return 7'h41;
           16: return 7'h0C;  17: return 7'h23;  18: return 7'h03;  19: return 7'h21;
           20: return 7'h2B;  21: return 7'h71;  22: return 7'h11;  30: return 7'h0B;
           default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_tick(input bit eight, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (((eight ? tick8 : frame_tick) !== 1'b1) && cyc < 2000);
        if (cyc >= 2000) begin
            checks++;
            fails++;
            $display("FAIL tick_timeout: no frame_tick within %0d cycles", cyc);
        end
    endtask

    // Scoreboard: expected outputs of the 4-digit instance, derived from elapsed cycles since reset.
    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } exp_t;
    exp_t sb_q[$];

    int         e;
    logic [4:0] m_act [4];
    logic [4:0] m_pend [4];
    logic [3:0] m_dpa, m_dpp, m_bla, m_blp;
    bit         m_pv;

    initial begin
        exp_t x;
        int slot, dig, f;
        bit ph, on;
        logic [4:0] c;
        forever begin
            @(posedge clk);
            if (reset) begin
                x = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, tick: 1'b0};
                e = 0;
                m_pv = 0;
                m_dpa = '0; m_dpp = '0; m_bla = '0; m_blp = '0;
                for (int k = 0; k < 4; k++) begin
                    m_act[k] = 5'd31;
                    m_pend[k] = 5'd31;
                end
            end else begin
                slot = e % S;
                dig  = N - 1 - (e / S) % N;
                f    = e / FR;
                ph   = ((f / BF) % 2) == 1;
                c    = m_act[dig];
                on   = (slot >= B) && ((slot / (S / 16)) <= int'(brightness)) && !(ph && m_bla[dig])
                    && ((ref_seg(int'(c)) != 7'h7F) || m_dpa[dig]);
                x.an   = on ? 4'(~(4'b0001 << dig)) : 4'hF;
                x.seg  = on ? ref_seg(int'(c)) : 7'h7F;
                x.dp   = on ? ~m_dpa[dig] : 1'b1;
                x.tick = (e % FR) == FR - 1;
                if ((e % FR) == FR - 1) begin
                    if (load) begin
                        for (int k = 0; k < 4; k++) m_act[k] = data_in[5*k +: 5];
                        m_dpa = dp_in;
                        m_bla = blink_mask;
                    end else if (m_pv) begin
                        for (int k = 0; k < 4; k++) m_act[k] = m_pend[k];
                        m_dpa = m_dpp;
                        m_bla = m_blp;
                    end
                    m_pv = 0;
                end else if (load) begin
                    for (int k = 0; k < 4; k++) m_pend[k] = data_in[5*k +: 5];
                    m_dpp = dp_in;
                    m_blp = blink_mask;
                    m_pv = 1;
                end
                e++;
            end
            sb_q.push_back(x);
        end
    end

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                checks++;
                if ({an, seg, dp, frame_tick} !== x) begin
                    fails++;
                    $display("FAIL scoreboard t=%0t: got an=%b seg=%h dp=%b tick=%b, expected an=%b seg=%h dp=%b tick=%b",
                             $time, an, seg, dp, frame_tick, x.an, x.seg, x.dp, x.tick);
                end
            end
        end
    end

    typedef struct packed {
        logic [19:0] data;
        logic [3:0]  dpv;
        logic [27:0] segs;
    } rec_t;

    initial begin
        rec_t tab [8];
        int cyc, cnt, cnt0, cnt3;
        logic [6:0] s;
        bit lt;

        tab[0] = '{{5'd1,  5'd2,  5'd3,  5'd4},  4'b0010, {7'h79, 7'h24, 7'h30, 7'h19}};
        tab[1] = '{{5'd0,  5'd5,  5'd6,  5'd7},  4'b0000, {7'h40, 7'h12, 7'h02, 7'h78}};
        tab[2] = '{{5'd8,  5'd9,  5'd10, 5'd11}, 4'b1001, {7'h00, 7'h10, 7'h3F, 7'h06}};
        tab[3] = '{{5'd12, 5'd13, 5'd14, 5'd15}, 4'b0100, {7'h2F, 7'h47, 7'h09, 7'h41}};
        tab[4] = '{{5'd16, 5'd17, 5'd18, 5'd19}, 4'b0000, {7'h0C, 7'h23, 7'h03, 7'h21}};
        tab[5] = '{{5'd20, 5'd21, 5'd22, 5'd30}, 4'b0001, {7'h2B, 7'h71, 7'h11, 7'h0B}};
        tab[6] = '{{5'd23, 5'd24, 5'd25, 5'd26}, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
        tab[7] = '{{5'd27, 5'd28, 5'd29, 5'd31}, 4'b1010, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};

        // Reset, first frame dark, first tick 256 cycles after release; load 1234 at cycle 10.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {19'd0, an, seg, dp, frame_tick}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
        reset = 1'b0;
        cnt = 0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (an !== 4'hF || seg !== 7'h7F) cnt++;
            if (cyc == 10) begin
                data_in = tab[0].data;
                dp_in   = tab[0].dpv;
                load    = 1'b1;
            end else begin
                load = 1'b0;
            end
        end while (frame_tick !== 1'b1 && cyc < 2000);
        chk("first_frame_dark", cnt, 0);
        chk("first_tick_cycle", cyc, 256);

        // Decoder vectors: each record becomes visible at the next boundary; sample slot 10 of each digit.
        for (int i = 0; i < 8; i++) begin
            data_in = tab[i].data;
            dp_in   = tab[i].dpv;
            load    = 1'b1;
            @(negedge clk);
            load = 1'b0;
            wait_tick(0, cyc);
            repeat (11) @(negedge clk);
            for (int d = 3; d >= 0; d--) begin
                s  = tab[i].segs[7*d +: 7];
                lt = (s != 7'h7F) || tab[i].dpv[d];
                chk($sformatf("table%0d_digit%0d", i, d), {20'd0, an, s == s ? seg : seg, dp},
                    lt ? {20'd0, 4'(~(4'b0001 << d)), s, ~tab[i].dpv[d]} : {20'd0, 4'hF, 7'h7F, 1'b1});
                if (d > 0) repeat (64) @(negedge clk);
            end
        end

        // Brightness: 2 lit cycles per slot at level 0, 30 at level 7.
        data_in = {5'd8, 5'd8, 5'd8, 5'd8};
        dp_in   = 4'b0000;
        load    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_tick(0, cyc);
        brightness = 4'd0;
        cnt = 0;
        repeat (FR) begin @(negedge clk); if (an !== 4'hF) cnt++; end
        chk("bright0_lit_cycles", cnt, 8);
        brightness = 4'd7;
        cnt = 0;
        repeat (FR) begin @(negedge clk); if (an !== 4'hF) cnt++; end
        chk("bright7_lit_cycles", cnt, 120);
        brightness = 4'd15;

        // Two loads in one frame: last one wins.
        repeat (20) @(negedge clk);
        data_in = {5'd5, 5'd5, 5'd5, 5'd5};
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (30) @(negedge clk);
        data_in = {5'd6, 5'd6, 5'd6, 5'd6};
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_tick(0, cyc);
        repeat (11) @(negedge clk);
        chk("last_load_wins", {21'd0, an, seg}, {21'd0, 4'b0111, 7'h02});

        // Load in the boundary cycle itself goes straight to the active set.
        repeat (244) @(negedge clk);
        data_in = {5'd7, 5'd7, 5'd7, 5'd7};
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("boundary_tick", {31'd0, frame_tick}, 32'd1);
        repeat (11) @(negedge clk);
        chk("boundary_load", {21'd0, an, seg}, {21'd0, 4'b0111, 7'h78});

        // Reset mid-slot discards a pending load.
        data_in = {5'd9, 5'd9, 5'd9, 5'd9};
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midslot_reset", {19'd0, an, seg, dp, frame_tick}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
        reset = 1'b0;
        cnt = 0;
        repeat (600) begin @(negedge clk); if (an !== 4'hF) cnt++; end
        chk("pending_discarded", cnt, 0);

        // Blink on digit 0 with phase derived from the frame count since reset.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        data_in    = {5'd1, 5'd2, 5'd3, 5'd4};
        dp_in      = 4'b0000;
        blink_mask = 4'b0001;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_tick(0, cyc);
        for (int f = 1; f <= 6; f++) begin
            cnt0 = 0;
            cnt3 = 0;
            repeat (FR) begin
                @(negedge clk);
                if (an === 4'b1110) cnt0++;
                if (an === 4'b0111) cnt3++;
            end
            chk($sformatf("blink_frame%0d_digit0", f), cnt0, (((f / BF) % 2) == 1) ? 0 : 62);
            chk($sformatf("blink_frame%0d_digit3", f), cnt3, 62);
        end

        // 8-digit instance: scan order, decoded codes 0..7, tick period 512.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        data8 = {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
        load8 = 1'b1;
        @(negedge clk);
        load8 = 1'b0;
        wait_tick(1, cyc);
        repeat (11) @(negedge clk);
        for (int d = 7; d >= 0; d--) begin
            chk($sformatf("scan8_digit%0d", d), {16'd0, an8, seg8, dp8_out},
                {16'd0, 8'(~(8'b1 << d)), ref_seg(7 - d), 1'b1});
            if (d > 0) repeat (64) @(negedge clk);
        end
        wait_tick(1, cyc);
        wait_tick(1, cyc);
        chk("tick8_period", cyc, 512);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
